multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style main FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, memory port and register file.
- Drives the immediate-format select consumed by the sign-extension unit, plus the mux selects, write enables and ALU control.
- Waits on a memory ready handshake and traps on unsupported encodings.

Parameters:
TRAP_STICKY, 1, 1: TRAP is held until reset; 0: TRAP lasts one cycle, then FETCH.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2, from the ALU subtract
ltu  in  1  unsigned rs1 < rs2
memrdy  in  1  memory completes the current access this cycle
pcwrite  out  1  PC register enable
adrsrc  out  1  memory address select: 0 = PC, 1 = Result
memwrite  out  1  data memory write strobe
irwrite  out  1  instruction and OldPC register enable
regwrite  out  1  register-file write enable
resultsrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alusrca  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
alusrcb  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
immsrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
alucontrol  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
illegal  out  1  high while in TRAP

Behaviour:
- Reset is asynchronous and active-high: state goes to FETCH. While reset is high every output is 0.
- First post-reset edge executes FETCH.
- immsrc is combinational from op in all states, so ImmExt is valid whenever consumed:
  - loads, OP-IMM, jalr → 000
  - stores → 001
  - branches → 010
  - jal → 011
  - lui, auipc → 100
  - unknown → 000
- Outputs not listed for a state are 0. alucontrol = add unless stated.
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10. irwrite=memrdy, pcwrite=memrdy. Stay in FETCH while !memrdy, otherwise → DECODE.
- DECODE: alusrca=01, alusrcb=01, add, so ALUOut = OldPC+ImmExt (branch/jal target, or the auipc result). Next state by op:
  - 0000011 (funct3 = 010 only) or 0100011 (funct3 = 010 only) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 (funct3 ∉ {010, 011}) → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → ALUWB
  - anything else → TRAP
- MEMADR: alusrca=10, alusrcb=01, add. → MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adrsrc=1, resultsrc=00. Hold while !memrdy, otherwise → MEMWB.
- MEMWB: resultsrc=01, regwrite=1 → FETCH.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1. Hold while !memrdy, otherwise → FETCH. memwrite stays high across all wait cycles.
- EXECR: alusrca=10, alusrcb=00, alucontrol from the ALU decoder → ALUWB.
- EXECI: alusrca=10, alusrcb=01, alucontrol from the ALU decoder → ALUWB.
- ALUWB: resultsrc=00, regwrite=1 → FETCH.
- BRANCH: alusrca=10, alusrcb=00, sub, resultsrc=00. pcwrite = taken, where taken is selected by funct3:
  - 000 zero, 001 !zero
  - 100 lt, 101 !lt
  - 110 ltu, 111 !ltu
  - → FETCH
- JAL: alusrca=01, alusrcb=10, resultsrc=00, pcwrite=1 → ALUWB (writes OldPC+4).
- JALR: alusrca=10, alusrcb=01, add, resultsrc=10, pcwrite=1 → LINK. Bit-0 clearing of the target is done by the datapath.
- LINK: alusrca=01, alusrcb=10 → ALUWB.
- LUI: alusrca=11, alusrcb=01 → ALUWB.
- TRAP: illegal=1, all enables 0. Exit via reset only if TRAP_STICKY=1, otherwise → FETCH next cycle.
- ALU decoder (EXECR/EXECI), by funct3:
  - 000: sub only if op is R-type and funct7b5=1, otherwise add
  - 001 sll, 010 slt, 011 sltu, 100 xor
  - 101: sra if funct7b5, otherwise srl
  - 110 or, 111 and
- Reset asserted mid-instruction: outputs drop to 0 asynchronously, no partial writes complete; restart in FETCH.
- Cycle counts with memrdy=1:
  - lw 5, sw 4
  - R/I-type 4, branch 3
  - jal 4, jalr 5
  - lui 4, auipc 3

Decomposition:
- Shared package riscv_pkg holds:
  - state enum
  - opcode constants
  - immsrc codes
  - alucontrol codes
  - resultsrc, alusrca and alusrcb encodings
- Sub-module alu_decoder: combinational funct3/funct7b5/op → alucontrol.
- The FSM is one module with a state register and a next-state/output always_comb.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), memrdy=1 → FETCH, DECODE, EXECR, ALUWB; alucontrol=0 in EXECR; regwrite=1 only in cycle 4. Repeat with f7b5=1 → alucontrol=1.
- lw with memrdy low for 3 cycles in MEMREAD → state held, adrsrc=1 throughout; regwrite in MEMWB only; total 8 cycles.
- bne (f3 001) with zero=1 → pcwrite=0 in BRANCH; with zero=0 → pcwrite=1; both return to FETCH after 3 cycles.
- jalr → immsrc=000; pcwrite in JALR with resultsrc=10; LINK then ALUWB with regwrite=1; 5 cycles.
- op=1111111 → TRAP, illegal=1, all enables 0 for 10 cycles (TRAP_STICKY=1); reset → FETCH, illegal=0.
- Reset pulsed during MEMWRITE wait → memwrite falls to 0 asynchronously; after release, FETCH with irwrite=memrdy.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// immediate-format codes, ALU operations and datapath mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, so it can be driven in every state.
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode for register and immediate arithmetic instructions.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alucontrol
);

  always_comb begin
    case (funct3)
      // instr[30] is part of the immediate for addi, so only R-type may subtract.
      3'b000:  alucontrol = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alucontrol = ALU_SLL;
      3'b010:  alucontrol = ALU_SLT;
      3'b011:  alucontrol = ALU_SLTU;
      3'b100:  alucontrol = ALU_XOR;
      3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alucontrol = ALU_OR;
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback, waits on memrdy and traps on unsupported encodings.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       memrdy,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] immsrc,
  output logic [3:0] alucontrol,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [3:0] alu_dec;
  logic       taken;
  logic       pcwrite_c, adrsrc_c, memwrite_c, irwrite_c, regwrite_c, illegal_c;
  logic [1:0] resultsrc_c, alusrca_c, alusrcb_c;
  logic [3:0] alucontrol_c;

  alu_decoder u_alu_decoder (
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .alucontrol(alu_dec)
  );

  // NOTE: state is the only flop; non-blocking assignment keeps every reader on the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    pcwrite_c    = 1'b0;
    adrsrc_c     = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    regwrite_c   = 1'b0;
    illegal_c    = 1'b0;
    resultsrc_c  = RES_ALUOUT;
    alusrca_c    = SRCA_PC;
    alusrcb_c    = SRCB_RS2;
    alucontrol_c = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb_c   = SRCB_FOUR;
        resultsrc_c = RES_ALURESULT;
        irwrite_c   = memrdy;
        pcwrite_c   = memrdy;
        if (memrdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrca_c = SRCA_OLDPC;
        alusrcb_c = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca_c = SRCA_RS1;
        alusrcb_c = SRCB_IMM;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc_c = 1'b1;
        if (memrdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc_c = RES_DATA;
        regwrite_c  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc_c   = 1'b1;
        memwrite_c = 1'b1;
        if (memrdy) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alusrca_c    = SRCA_RS1;
        alusrcb_c    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        alucontrol_c = alu_dec;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c    = SRCA_RS1;
        alucontrol_c = ALU_SUB;
        pcwrite_c    = taken;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        alusrca_c = SRCA_OLDPC;
        alusrcb_c = SRCB_FOUR;
        pcwrite_c = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alusrca_c   = SRCA_RS1;
        alusrcb_c   = SRCB_IMM;
        resultsrc_c = RES_ALURESULT;
        pcwrite_c   = 1'b1;
        state_d     = S_LINK;
      end
      S_LINK: begin
        alusrca_c = SRCA_OLDPC;
        alusrcb_c = SRCB_FOUR;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alusrca_c = SRCA_ZERO;
        alusrcb_c = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
        state_d   = TRAP_STICKY ? S_TRAP : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: outputs are gated by reset itself so enables drop asynchronously, not on the next edge.
  assign pcwrite    = pcwrite_c  & ~reset;
  assign adrsrc     = adrsrc_c   & ~reset;
  assign memwrite   = memwrite_c & ~reset;
  assign irwrite    = irwrite_c  & ~reset;
  assign regwrite   = regwrite_c & ~reset;
  assign illegal    = illegal_c  & ~reset;
  assign resultsrc  = reset ? 2'b00 : resultsrc_c;
  assign alusrca    = reset ? 2'b00 : alusrca_c;
  assign alusrcb    = reset ? 2'b00 : alusrcb_c;
  assign immsrc     = reset ? 3'b000 : imm_sel(op);
  assign alucontrol = reset ? 4'd0 : alucontrol_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle check of the multicycle controller's control word.
module tb_multicycle_controller;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, memrdy;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] immsrc;
  logic [3:0] alucontrol;
  logic [18:0] obs_ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TRAP_STICKY(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .memrdy    (memrdy),
    .pcwrite   (pcwrite),
    .adrsrc    (adrsrc),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .resultsrc (resultsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .immsrc    (immsrc),
    .alucontrol(alucontrol),
    .illegal   (illegal)
  );

  assign obs_ctl = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                    alusrca, alusrcb, immsrc, alucontrol, illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Control word: pcw adr mw irw rw | resultsrc alusrca alusrcb | immsrc | alucontrol | illegal
  function automatic logic [18:0] mk(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  function automatic logic [18:0] fetch_exp(input logic [2:0] imm, input logic rdy);
    return mk(rdy, 0, 0, rdy, 0, 2'b10, 2'b00, 2'b10, imm, 4'd0, 0);
  endfunction

  function automatic logic [18:0] decode_exp(input logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'd0, 0);
  endfunction

  function automatic logic [18:0] aluwb_exp(input logic [2:0] imm);
    return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 4'd0, 0);
  endfunction

  // Called at a falling edge with inputs already set; samples, then advances one cycle.
  task automatic cyc(input string tag, input logic [18:0] exp);
    #1;
    check(tag, {13'd0, obs_ctl}, {13'd0, exp});
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check(tag, {13'd0, obs_ctl}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    memrdy = 1'b1;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    set_instr(OP_BRANCH, 3'b000, 1'b0);
    @(negedge clk);
    #1 check("reset_outputs_zero", {13'd0, obs_ctl}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // add, then sub
    set_instr(OP_R, 3'b000, 1'b0);
    cyc("add_fetch", fetch_exp(IMM_I, 1));
    cyc("add_decode", decode_exp(IMM_I));
    cyc("add_execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IMM_I, ALU_ADD, 0));
    cyc("add_aluwb", aluwb_exp(IMM_I));
    set_instr(OP_R, 3'b000, 1'b1);
    cyc("sub_fetch", fetch_exp(IMM_I, 1));
    cyc("sub_decode", decode_exp(IMM_I));
    cyc("sub_execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IMM_I, ALU_SUB, 0));
    cyc("sub_aluwb", aluwb_exp(IMM_I));

    // addi with instr[30] set must still add; srai selects sra
    set_instr(OP_IMM, 3'b000, 1'b1);
    cyc("addi_fetch", fetch_exp(IMM_I, 1));
    cyc("addi_decode", decode_exp(IMM_I));
    cyc("addi_execi", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, IMM_I, ALU_ADD, 0));
    cyc("addi_aluwb", aluwb_exp(IMM_I));
    set_instr(OP_IMM, 3'b101, 1'b1);
    cyc("srai_fetch", fetch_exp(IMM_I, 1));
    cyc("srai_decode", decode_exp(IMM_I));
    cyc("srai_execi", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, IMM_I, ALU_SRA, 0));
    cyc("srai_aluwb", aluwb_exp(IMM_I));

    // lw with three memory wait cycles: 8 cycles total
    set_instr(OP_LOAD, 3'b010, 1'b0);
    cyc("lw_fetch", fetch_exp(IMM_I, 1));
    cyc("lw_decode", decode_exp(IMM_I));
    cyc("lw_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, IMM_I, ALU_ADD, 0));
    memrdy = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("lw_memread_wait%0d", i), mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, 4'd0, 0));
    memrdy = 1'b1;
    cyc("lw_memread_done", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, 4'd0, 0));
    cyc("lw_memwb", mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, IMM_I, 4'd0, 0));

    // bne not taken / taken, bltu taken, bge not taken
    set_instr(OP_BRANCH, 3'b001, 1'b0);
    zero = 1'b1;
    cyc("bne_nt_fetch", fetch_exp(IMM_B, 1));
    cyc("bne_nt_decode", decode_exp(IMM_B));
    cyc("bne_nt_branch", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IMM_B, ALU_SUB, 0));
    zero = 1'b0;
    cyc("bne_t_fetch", fetch_exp(IMM_B, 1));
    cyc("bne_t_decode", decode_exp(IMM_B));
    cyc("bne_t_branch", mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IMM_B, ALU_SUB, 0));
    set_instr(OP_BRANCH, 3'b110, 1'b0);
    ltu = 1'b1;
    cyc("bltu_fetch", fetch_exp(IMM_B, 1));
    cyc("bltu_decode", decode_exp(IMM_B));
    cyc("bltu_branch", mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IMM_B, ALU_SUB, 0));
    set_instr(OP_BRANCH, 3'b101, 1'b0);
    ltu = 1'b0; lt = 1'b1;
    cyc("bge_fetch", fetch_exp(IMM_B, 1));
    cyc("bge_decode", decode_exp(IMM_B));
    cyc("bge_branch", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IMM_B, ALU_SUB, 0));
    lt = 1'b0;

    // jal: 4 cycles; jalr: 5 cycles
    set_instr(OP_JAL, 3'b000, 1'b0);
    cyc("jal_fetch", fetch_exp(IMM_J, 1));
    cyc("jal_decode", decode_exp(IMM_J));
    cyc("jal_jal", mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, IMM_J, 4'd0, 0));
    cyc("jal_aluwb", aluwb_exp(IMM_J));
    set_instr(OP_JALR, 3'b000, 1'b0);
    cyc("jalr_fetch", fetch_exp(IMM_I, 1));
    cyc("jalr_decode", decode_exp(IMM_I));
    cyc("jalr_jalr", mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, IMM_I, ALU_ADD, 0));
    cyc("jalr_link", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, IMM_I, 4'd0, 0));
    cyc("jalr_aluwb", aluwb_exp(IMM_I));

    // lui: 4 cycles; auipc: 3 cycles
    set_instr(OP_LUI, 3'b000, 1'b0);
    cyc("lui_fetch", fetch_exp(IMM_U, 1));
    cyc("lui_decode", decode_exp(IMM_U));
    cyc("lui_lui", mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, IMM_U, 4'd0, 0));
    cyc("lui_aluwb", aluwb_exp(IMM_U));
    set_instr(OP_AUIPC, 3'b000, 1'b0);
    cyc("auipc_fetch", fetch_exp(IMM_U, 1));
    cyc("auipc_decode", decode_exp(IMM_U));
    cyc("auipc_aluwb", aluwb_exp(IMM_U));

    // sw held by memrdy, reset pulsed mid-wait, then a clean sw
    set_instr(OP_STORE, 3'b010, 1'b0);
    cyc("sw_fetch", fetch_exp(IMM_S, 1));
    cyc("sw_decode", decode_exp(IMM_S));
    cyc("sw_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, IMM_S, ALU_ADD, 0));
    memrdy = 1'b0;
    cyc("sw_memwrite_wait0", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, IMM_S, 4'd0, 0));
    #1 check("sw_memwrite_wait1", {13'd0, obs_ctl}, {13'd0, mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, IMM_S, 4'd0, 0)});
    #1 pulse_reset("sw_reset_async");
    cyc("sw_restart_fetch_wait", fetch_exp(IMM_S, 0));
    memrdy = 1'b1;
    cyc("sw_restart_fetch", fetch_exp(IMM_S, 1));
    cyc("sw2_decode", decode_exp(IMM_S));
    cyc("sw2_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, IMM_S, ALU_ADD, 0));
    cyc("sw2_memwrite", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, IMM_S, 4'd0, 0));
    cyc("sw2_back_to_fetch", fetch_exp(IMM_S, 1));

    // lb (funct3 000) is unsupported and traps
    set_instr(OP_LOAD, 3'b000, 1'b0);
    cyc("lb_decode", decode_exp(IMM_I));
    cyc("lb_trap", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, 4'd0, 1));
    pulse_reset("lb_trap_reset");

    // unknown opcode: sticky trap for 10 cycles, then reset
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc("bad_fetch", fetch_exp(IMM_I, 1));
    cyc("bad_decode", decode_exp(IMM_I));
    for (int i = 0; i < 10; i++)
      cyc($sformatf("bad_trap%0d", i), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, 4'd0, 1));
    pulse_reset("bad_trap_reset");
    cyc("after_trap_fetch", fetch_exp(IMM_I, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
